dma_bus_fsm: RTL and testbench

- CPCI-side DMA bus controller for the NetFPGA control-path DMA engine.
- Decodes host DMA operation requests (query, transmit, receive) arriving on the CPCI pins.
- Transmit: moves host words into the transmit clock-crossing FIFO, tagged with a request word and per-word byte counts/EOP.
- Receive: streams packet words from the receive clock-crossing FIFO onto the CPCI data bus under host flow control.

---
 rtl/dma_bus_fsm.sv | 220 ++++++++++++++++++++++
 tb/tb_dma_bus_fsm.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_bus_fsm.sv
// dma_bus_fsm
// CPCI-side bus controller for the control-path DMA engine. Decodes host
// DMA requests (query / rx / tx), pushes host words into the transmit
// clock-crossing FIFO behind a request word, and streams packet words from
// the receive FIFO onto the CPCI data bus under host flow control.
//
// Ports:
//   cpci_clk, cpci_reset          clock, synchronous active-low reset
//   enable_dma                    gates leaving IDLE only
//   dma_op_code_req/_queue_id     host request and target queue
//   dma_op_code_ack               completion code (op code while in DONE)
//   dma_vld_c2n, dma_data_c2n     host -> NetFPGA data
//   dma_dest_q_nearly_full_n2c    back-pressure to host (tx only)
//   dma_vld_n2c, dma_data_n2c     NetFPGA -> host data / status
//   dma_dest_q_nearly_full_c2n    host back-pressure for rx stream
//   dma_data_tri_en               1 = NetFPGA drives the shared bus
//   cpu_q_dma_pkt_avail/_nearly_full  per-queue status
//   txfifo_*                      transmit FIFO write side
//   rxfifo_*                      receive FIFO read side (first-word-fall-through)
//
// state   | meaning
// IDLE    | waiting for an enabled request
// QUERY   | registering the queue status word
// TX_REQ  | writing the tx request word
// TX_LEN  | waiting for the host length word
// TX_DATA | forwarding host words until eop
// RX_REQ  | writing the rx request word
// RX_DATA | streaming rx FIFO words to the host until eop
// DONE    | acknowledging until the host drops the request
module dma_bus_fsm #(
  parameter int DMA_DATA_WIDTH    = 32,
  parameter int NUM_CPU_QUEUES    = 4,
  parameter int PKT_LEN_CNT_WIDTH = 11
) (
  input  logic                        cpci_clk,
  input  logic                        cpci_reset,
  input  logic                        enable_dma,
  input  logic [1:0]                  dma_op_code_req,
  input  logic [3:0]                  dma_op_queue_id,
  output logic [1:0]                  dma_op_code_ack,
  input  logic                        dma_vld_c2n,
  input  logic [DMA_DATA_WIDTH-1:0]   dma_data_c2n,
  output logic                        dma_dest_q_nearly_full_n2c,
  output logic                        dma_vld_n2c,
  output logic [DMA_DATA_WIDTH-1:0]   dma_data_n2c,
  input  logic                        dma_dest_q_nearly_full_c2n,
  output logic                        dma_data_tri_en,
  input  logic [NUM_CPU_QUEUES-1:0]   cpu_q_dma_pkt_avail,
  input  logic [NUM_CPU_QUEUES-1:0]   cpu_q_dma_nearly_full,
  input  logic                        txfifo_full,
  input  logic                        txfifo_nearly_full,
  output logic                        txfifo_wr,
  output logic [DMA_DATA_WIDTH+3:0]   txfifo_wr_data,
  input  logic                        rxfifo_empty,
  input  logic [DMA_DATA_WIDTH+2:0]   rxfifo_rd_data,
  output logic                        rxfifo_rd_inc
);

  localparam int QW = (NUM_CPU_QUEUES > 1) ? $clog2(NUM_CPU_QUEUES) : 1;
  localparam logic [4:0] NUM_Q = 5'(NUM_CPU_QUEUES);
  localparam logic [PKT_LEN_CNT_WIDTH-1:0] WORD_BYTES = PKT_LEN_CNT_WIDTH'(4);

  typedef enum logic [2:0] {
    IDLE, QUERY, TX_REQ, TX_LEN, TX_DATA, RX_REQ, RX_DATA, DONE
  } state_t;

  state_t                       state, state_nxt;
  logic [1:0]                   op, op_nxt;
  logic [3:0]                   q, q_nxt;
  logic [PKT_LEN_CNT_WIDTH-1:0] rem, rem_nxt;
  logic [DMA_DATA_WIDTH-1:0]    data_reg, data_reg_nxt;
  logic                         tri_hold, tri_hold_nxt;

  logic                         q_ok;
  logic                         tx_eop;
  logic [1:0]                   tx_bytecnt;
  logic [PKT_LEN_CNT_WIDTH-1:0] len_word;

  assign q_ok       = {1'b0, dma_op_queue_id} < NUM_Q;
  assign tx_eop     = rem <= WORD_BYTES;
  assign tx_bytecnt = (rem >= WORD_BYTES) ? 2'b00 : rem[1:0];
  assign len_word   = dma_data_c2n[PKT_LEN_CNT_WIDTH-1:0];

  always_ff @(posedge cpci_clk) begin
    if (!cpci_reset) begin
      state    <= IDLE;
      op       <= 2'b00;
      q        <= 4'd0;
      rem      <= '0;
      data_reg <= '0;
      tri_hold <= 1'b0;
    end else begin
      state    <= state_nxt;
      op       <= op_nxt;
      q        <= q_nxt;
      rem      <= rem_nxt;
      data_reg <= data_reg_nxt;
      tri_hold <= tri_hold_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    op_nxt       = op;
    q_nxt        = q;
    rem_nxt      = rem;
    data_reg_nxt = data_reg;
    tri_hold_nxt = tri_hold;

    dma_op_code_ack            = 2'b00;
    dma_dest_q_nearly_full_n2c = 1'b0;
    dma_vld_n2c                = 1'b0;
    dma_data_n2c               = data_reg;
    dma_data_tri_en            = 1'b0;
    txfifo_wr                  = 1'b0;
    txfifo_wr_data             = '0;
    rxfifo_rd_inc              = 1'b0;

    case (state)
      IDLE: begin
        if (enable_dma && dma_op_code_req != 2'b00) begin
          op_nxt       = dma_op_code_req;
          q_nxt        = dma_op_queue_id;
          tri_hold_nxt = 1'b0;
          if (!q_ok)
            state_nxt = DONE;
          else if (dma_op_code_req == 2'b01)
            state_nxt = QUERY;
          else if (dma_op_code_req == 2'b10)
            state_nxt = RX_REQ;
          else
            state_nxt = TX_REQ;
        end
      end

      QUERY: begin
        dma_data_tri_en = 1'b1;
        data_reg_nxt    = {{(DMA_DATA_WIDTH-2*NUM_CPU_QUEUES){1'b0}},
                           cpu_q_dma_nearly_full, cpu_q_dma_pkt_avail};
        tri_hold_nxt    = 1'b1;
        state_nxt       = DONE;
      end

      TX_REQ: begin
        if (!txfifo_full) begin
          txfifo_wr      = 1'b1;
          txfifo_wr_data = {1'b1, 1'b0, 2'b00, {(DMA_DATA_WIDTH-4){1'b0}}, q};
          state_nxt      = TX_LEN;
        end
      end

      TX_LEN: begin
        dma_dest_q_nearly_full_n2c = txfifo_nearly_full | cpu_q_dma_nearly_full[q[QW-1:0]];
        if (dma_vld_c2n) begin
          rem_nxt   = len_word;
          state_nxt = (len_word == '0) ? DONE : TX_DATA;
        end
      end

      TX_DATA: begin
        dma_dest_q_nearly_full_n2c = txfifo_nearly_full | cpu_q_dma_nearly_full[q[QW-1:0]];
        // Words arriving while the FIFO is full are lost and do not count.
        if (dma_vld_c2n && !txfifo_full) begin
          txfifo_wr      = 1'b1;
          txfifo_wr_data = {1'b0, tx_eop, tx_bytecnt, dma_data_c2n};
          rem_nxt        = (rem > WORD_BYTES) ? rem - WORD_BYTES : '0;
          if (tx_eop)
            state_nxt = DONE;
        end
      end

      RX_REQ: begin
        if (!txfifo_full) begin
          txfifo_wr      = 1'b1;
          txfifo_wr_data = {1'b1, 1'b1, 2'b00, {(DMA_DATA_WIDTH-4){1'b0}}, q};
          state_nxt      = RX_DATA;
        end
      end

      RX_DATA: begin
        dma_data_tri_en = 1'b1;
        if (!rxfifo_empty && !dma_dest_q_nearly_full_c2n) begin
          dma_vld_n2c   = 1'b1;
          rxfifo_rd_inc = 1'b1;
          dma_data_n2c  = rxfifo_rd_data[DMA_DATA_WIDTH-1:0];
          data_reg_nxt  = rxfifo_rd_data[DMA_DATA_WIDTH-1:0];
          if (rxfifo_rd_data[DMA_DATA_WIDTH+2]) begin
            tri_hold_nxt = 1'b1;
            state_nxt    = DONE;
          end
        end
      end

      DONE: begin
        dma_op_code_ack = op;
        dma_data_tri_en = tri_hold;
        if (dma_op_code_req == 2'b00) begin
          tri_hold_nxt = 1'b0;
          state_nxt    = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase

    // Hold every output quiet while reset is asserted so an interrupted
    // transfer cannot emit a final (eop) write on the reset edge.
    if (!cpci_reset) begin
      dma_op_code_ack            = 2'b00;
      dma_dest_q_nearly_full_n2c = 1'b0;
      dma_vld_n2c                = 1'b0;
      dma_data_n2c               = '0;
      dma_data_tri_en            = 1'b0;
      txfifo_wr                  = 1'b0;
      txfifo_wr_data             = '0;
      rxfifo_rd_inc              = 1'b0;
    end
  end

endmodule

// File: tb/tb_dma_bus_fsm.sv
module tb_dma_bus_fsm;

  logic        cpci_clk = 1'b0;
  logic        cpci_reset;
  logic        enable_dma;
  logic [1:0]  dma_op_code_req;
  logic [3:0]  dma_op_queue_id;
  logic [1:0]  dma_op_code_ack;
  logic        dma_vld_c2n;
  logic [31:0] dma_data_c2n;
  logic        dma_dest_q_nearly_full_n2c;
  logic        dma_vld_n2c;
  logic [31:0] dma_data_n2c;
  logic        dma_dest_q_nearly_full_c2n;
  logic        dma_data_tri_en;
  logic [3:0]  cpu_q_dma_pkt_avail;
  logic [3:0]  cpu_q_dma_nearly_full;
  logic        txfifo_full;
  logic        txfifo_nearly_full;
  logic        txfifo_wr;
  logic [35:0] txfifo_wr_data;
  logic        rxfifo_empty;
  logic [34:0] rxfifo_rd_data;
  logic        rxfifo_rd_inc;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  dma_bus_fsm dut (
    .cpci_clk                   (cpci_clk),
    .cpci_reset                 (cpci_reset),
    .enable_dma                 (enable_dma),
    .dma_op_code_req            (dma_op_code_req),
    .dma_op_queue_id            (dma_op_queue_id),
    .dma_op_code_ack            (dma_op_code_ack),
    .dma_vld_c2n                (dma_vld_c2n),
    .dma_data_c2n               (dma_data_c2n),
    .dma_dest_q_nearly_full_n2c (dma_dest_q_nearly_full_n2c),
    .dma_vld_n2c                (dma_vld_n2c),
    .dma_data_n2c               (dma_data_n2c),
    .dma_dest_q_nearly_full_c2n (dma_dest_q_nearly_full_c2n),
    .dma_data_tri_en            (dma_data_tri_en),
    .cpu_q_dma_pkt_avail        (cpu_q_dma_pkt_avail),
    .cpu_q_dma_nearly_full      (cpu_q_dma_nearly_full),
    .txfifo_full                (txfifo_full),
    .txfifo_nearly_full         (txfifo_nearly_full),
    .txfifo_wr                  (txfifo_wr),
    .txfifo_wr_data             (txfifo_wr_data),
    .rxfifo_empty               (rxfifo_empty),
    .rxfifo_rd_data             (rxfifo_rd_data),
    .rxfifo_rd_inc              (rxfifo_rd_inc)
  );

  always #5 cpci_clk = ~cpci_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Inputs change on the falling edge; settle #1 before sampling.
  task automatic tick();
    @(negedge cpci_clk);
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    cpci_reset = 1'b0;
    enable_dma = 1'b1;
    dma_op_code_req = 2'b00;
    dma_op_queue_id = 4'd0;
    dma_vld_c2n = 1'b0;
    dma_data_c2n = '0;
    dma_dest_q_nearly_full_c2n = 1'b0;
    cpu_q_dma_pkt_avail = '0;
    cpu_q_dma_nearly_full = '0;
    txfifo_full = 1'b0;
    txfifo_nearly_full = 1'b0;
    rxfifo_empty = 1'b1;
    rxfifo_rd_data = '0;

    // Reset
    repeat (3) tick();
    settle();
    check("rst_ack", dma_op_code_ack, 2'b00);
    check("rst_tri", dma_data_tri_en, 1'b0);
    check("rst_wr", txfifo_wr, 1'b0);
    check("rst_vld", dma_vld_n2c, 1'b0);
    check("rst_rdinc", rxfifo_rd_inc, 1'b0);
    check("rst_data", dma_data_n2c, 32'h0);
    cpci_reset = 1'b1;

    // enable_dma=0 blocks a request
    tick();
    enable_dma = 1'b0;
    dma_op_code_req = 2'b01;
    tick(); settle();
    check("dis_tri", dma_data_tri_en, 1'b0);
    tick(); settle();
    check("dis_ack", dma_op_code_ack, 2'b00);
    dma_op_code_req = 2'b00;
    enable_dma = 1'b1;

    // Query
    tick();
    cpu_q_dma_pkt_avail = 4'b0101;
    cpu_q_dma_nearly_full = 4'b0010;
    dma_op_code_req = 2'b01;
    tick(); settle();
    check("qry_tri_q", dma_data_tri_en, 1'b1);
    tick(); settle();
    check("qry_data", dma_data_n2c, 32'h25);
    check("qry_tri", dma_data_tri_en, 1'b1);
    check("qry_ack", dma_op_code_ack, 2'b01);
    dma_op_code_req = 2'b00;
    settle();
    check("qry_ack_hold", dma_op_code_ack, 2'b01);
    tick(); settle();
    check("qry_ack_drop", dma_op_code_ack, 2'b00);
    check("qry_tri_drop", dma_data_tri_en, 1'b0);
    cpu_q_dma_nearly_full = 4'b0000;

    // TX 6 bytes to q=2
    dma_op_code_req = 2'b11;
    dma_op_queue_id = 4'd2;
    tick(); settle();
    check("tx_req_wr", txfifo_wr, 1'b1);
    check("tx_req_data", txfifo_wr_data, 36'h8_0000_0002);
    tick();
    dma_vld_c2n = 1'b1;
    dma_data_c2n = 32'd6;
    settle();
    check("tx_len_nowr", txfifo_wr, 1'b0);
    check("tx_len_nf", dma_dest_q_nearly_full_n2c, 1'b0);
    tick();
    dma_data_c2n = 32'hAAAA5555;
    settle();
    check("tx_w0_wr", txfifo_wr, 1'b1);
    check("tx_w0_data", txfifo_wr_data, 36'h0_AAAA5555);
    tick();
    dma_data_c2n = 32'h12345678;
    settle();
    check("tx_w1_wr", txfifo_wr, 1'b1);
    check("tx_w1_data", txfifo_wr_data, 36'h6_12345678);
    tick();
    dma_vld_c2n = 1'b0;
    settle();
    check("tx_done_ack", dma_op_code_ack, 2'b11);
    check("tx_done_wr", txfifo_wr, 1'b0);
    check("tx_done_tri", dma_data_tri_en, 1'b0);
    dma_op_code_req = 2'b00;
    tick(); settle();
    check("tx_idle_ack", dma_op_code_ack, 2'b00);

    // TX with FIFO full at request and queue back-pressure
    dma_op_code_req = 2'b11;
    dma_op_queue_id = 4'd2;
    txfifo_full = 1'b1;
    tick(); settle();
    check("bp_full_nowr", txfifo_wr, 1'b0);
    tick(); settle();
    check("bp_full_nowr2", txfifo_wr, 1'b0);
    txfifo_full = 1'b0;
    settle();
    check("bp_req_wr", txfifo_wr, 1'b1);
    check("bp_req_data", txfifo_wr_data, 36'h8_0000_0002);
    tick();
    cpu_q_dma_nearly_full = 4'b0100;
    settle();
    check("bp_qnf", dma_dest_q_nearly_full_n2c, 1'b1);
    cpu_q_dma_nearly_full = 4'b1011;
    settle();
    check("bp_other_q", dma_dest_q_nearly_full_n2c, 1'b0);
    dma_vld_c2n = 1'b1;
    dma_data_c2n = 32'd4;
    tick();
    cpu_q_dma_nearly_full = 4'b0000;
    txfifo_nearly_full = 1'b1;
    dma_data_c2n = 32'hDEADBEEF;
    settle();
    check("bp_fifo_nf", dma_dest_q_nearly_full_n2c, 1'b1);
    check("bp_w0_data", txfifo_wr_data, 36'h4_DEADBEEF);
    tick();
    dma_vld_c2n = 1'b0;
    settle();
    check("bp_done_nf", dma_dest_q_nearly_full_n2c, 1'b0);
    check("bp_done_ack", dma_op_code_ack, 2'b11);
    txfifo_nearly_full = 1'b0;
    dma_op_code_req = 2'b00;
    tick();

    // RX from q=1, three words with a 2-cycle host stall
    dma_op_code_req = 2'b10;
    dma_op_queue_id = 4'd1;
    tick(); settle();
    check("rx_req_wr", txfifo_wr, 1'b1);
    check("rx_req_data", txfifo_wr_data, 36'hC_0000_0001);
    tick();
    rxfifo_empty = 1'b0;
    rxfifo_rd_data = {1'b0, 2'b00, 32'h11111111};
    settle();
    check("rx_w0_vld", dma_vld_n2c, 1'b1);
    check("rx_w0_inc", rxfifo_rd_inc, 1'b1);
    check("rx_w0_data", dma_data_n2c, 32'h11111111);
    check("rx_tri", dma_data_tri_en, 1'b1);
    tick();
    rxfifo_rd_data = {1'b0, 2'b00, 32'h22222222};
    dma_dest_q_nearly_full_c2n = 1'b1;
    settle();
    check("rx_stall1_vld", dma_vld_n2c, 1'b0);
    check("rx_stall1_inc", rxfifo_rd_inc, 1'b0);
    tick(); settle();
    check("rx_stall2_vld", dma_vld_n2c, 1'b0);
    check("rx_stall2_inc", rxfifo_rd_inc, 1'b0);
    tick();
    dma_dest_q_nearly_full_c2n = 1'b0;
    settle();
    check("rx_w1_vld", dma_vld_n2c, 1'b1);
    check("rx_w1_data", dma_data_n2c, 32'h22222222);
    check("rx_w1_inc", rxfifo_rd_inc, 1'b1);
    tick();
    rxfifo_rd_data = {1'b1, 2'b11, 32'h33333333};
    settle();
    check("rx_w2_vld", dma_vld_n2c, 1'b1);
    check("rx_w2_data", dma_data_n2c, 32'h33333333);
    tick();
    rxfifo_empty = 1'b1;
    settle();
    check("rx_done_ack", dma_op_code_ack, 2'b10);
    check("rx_done_vld", dma_vld_n2c, 1'b0);
    check("rx_done_inc", rxfifo_rd_inc, 1'b0);
    check("rx_done_tri", dma_data_tri_en, 1'b1);
    dma_op_code_req = 2'b00;
    tick(); settle();
    check("rx_idle_ack", dma_op_code_ack, 2'b00);
    check("rx_idle_tri", dma_data_tri_en, 1'b0);

    // Reset in the middle of a TX packet
    dma_op_code_req = 2'b11;
    dma_op_queue_id = 4'd3;
    tick();
    tick();
    dma_vld_c2n = 1'b1;
    dma_data_c2n = 32'd8;
    tick();
    dma_data_c2n = 32'hCAFE0001;
    settle();
    check("mid_w0_data", txfifo_wr_data, 36'h0_CAFE0001);
    tick();
    dma_data_c2n = 32'hCAFE0002;
    cpci_reset = 1'b0;
    settle();
    check("mid_rst_wr", txfifo_wr, 1'b0);
    tick();
    cpci_reset = 1'b1;
    dma_vld_c2n = 1'b0;
    dma_op_code_req = 2'b00;
    txfifo_nearly_full = 1'b1;
    settle();
    check("mid_idle_wr", txfifo_wr, 1'b0);
    check("mid_idle_nf", dma_dest_q_nearly_full_n2c, 1'b0);
    check("mid_idle_ack", dma_op_code_ack, 2'b00);
    txfifo_nearly_full = 1'b0;

    // Bad queue id goes straight to DONE
    dma_op_code_req = 2'b11;
    dma_op_queue_id = 4'd7;
    settle();
    check("badq_idle_wr", txfifo_wr, 1'b0);
    tick(); settle();
    check("badq_ack", dma_op_code_ack, 2'b11);
    check("badq_wr", txfifo_wr, 1'b0);
    dma_op_code_req = 2'b00;
    tick(); settle();
    check("badq_idle_ack", dma_op_code_ack, 2'b00);
    check("badq_idle_wr2", txfifo_wr, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
